// File: rtl/seq_tx.sv
// Serial pattern transmitter: latches an 8-bit word on a start press and shifts it out
// LSB-first, one bit per DIV cycles, running a "101" detector over the emitted bits.
module seq_tx #(
   parameter int unsigned DIV = 25000000
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       K0,
   input  logic       K1,
   input  logic [7:0] Ks,
   output logic       SDO,
   output logic       SSTB,
   output logic       BUSY,
   output logic       L1,
   output logic       L2,
   output logic       L3,
   output logic       L4,
   output logic       L5,
   output logic       L6,
   output logic       L7,
   output logic       L8,
   output logic [7:0] NUM
);

   localparam logic [31:0] DivLast = 32'(DIV - 1);

   localparam logic [2:0] DetS0 = 3'b001;
   localparam logic [2:0] DetS1 = 3'b010;
   localparam logic [2:0] DetS2 = 3'b100;

   typedef enum logic [1:0] {
      StIdle,
      StSend,
      StDone
   } state_e;

   state_e state_q, state_d;

   logic        k0_s1, k0_s2, k0_q, start_q;
   logic [7:0]  shift_q;
   logic        mode_q;
   logic [2:0]  idx_q;
   logic [31:0] div_q;
   logic [2:0]  det_q, det_d;
   logic [7:0]  flags_q;
   logic [2:0]  cnt_q;
   logic        hit;
   logic        bit_end;
   logic        start_ok;
   logic [6:0]  seg;

   // ---------------------------------------------------------------- state register
   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------- next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (start_q) state_d = StSend;
         StSend:  if (bit_end && (idx_q == 3'd7)) state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // ---------------------------------------------------------------- frame outputs
   always_comb begin
      BUSY     = (state_q == StSend);
      SSTB     = BUSY && (div_q == 32'd0);
      SDO      = BUSY && shift_q[0];
      bit_end  = BUSY && (div_q == DivLast);
      start_ok = (state_q == StIdle) && start_q;
   end

   // Detector sees the bit currently on SDO; only consulted on the strobe cycle.
   always_comb begin
      det_d = det_q;
      hit   = 1'b0;
      unique case (det_q)
         DetS0: det_d = shift_q[0] ? DetS1 : DetS0;
         DetS1: det_d = shift_q[0] ? DetS1 : DetS2;
         DetS2: begin
            if (shift_q[0]) begin
               hit   = 1'b1;
               det_d = mode_q ? DetS1 : DetS0;
            end else begin
               det_d = DetS0;
            end
         end
         default: det_d = DetS0;
      endcase
   end

   // ---------------------------------------------------------------- datapath
   always_ff @(posedge CLK) begin
      if (!RST) begin
         k0_s1   <= 1'b0;
         k0_s2   <= 1'b0;
         k0_q    <= 1'b0;
         start_q <= 1'b0;
         shift_q <= 8'd0;
         mode_q  <= 1'b0;
         idx_q   <= 3'd0;
         div_q   <= 32'd0;
         det_q   <= DetS0;
         flags_q <= 8'd0;
         cnt_q   <= 3'd0;
      end else begin
         k0_s1   <= K0;
         k0_s2   <= k0_s1;
         k0_q    <= k0_s2;
         start_q <= k0_s2 & ~k0_q;

         if (start_ok) begin
            shift_q <= Ks;
            mode_q  <= K1;
            idx_q   <= 3'd0;
            div_q   <= 32'd0;
            det_q   <= DetS0;
            flags_q <= 8'd0;
            cnt_q   <= 3'd0;
         end else if (BUSY) begin
            if (bit_end) begin
               div_q   <= 32'd0;
               shift_q <= {1'b0, shift_q[7:1]};
               idx_q   <= idx_q + 3'd1;
            end else begin
               div_q <= div_q + 32'd1;
            end
            if (SSTB) begin
               det_q <= det_d;
               if (hit) begin
                  flags_q[idx_q] <= 1'b1;
                  // At most three matches fit in eight bits, so no saturation.
                  cnt_q          <= cnt_q + 3'd1;
               end
            end
         end
      end
   end

   // ---------------------------------------------------------------- indicators
   always_comb begin
      {L8, L7, L6, L5, L4, L3, L2, L1} = flags_q;
   end

   always_comb begin
      seg = 7'b0000000;
      case (cnt_q)
         3'd0:    seg = 7'b1111110;
         3'd1:    seg = 7'b0110000;
         3'd2:    seg = 7'b1101101;
         3'd3:    seg = 7'b1111001;
         default: seg = 7'b0000000;
      endcase
      NUM = {seg, 1'b0};
   end

endmodule

// File: tb/tb_seq_tx.sv
// Scoreboard bench for seq_tx: expected bits are queued at launch and popped on each strobe.
module tb_seq_tx;

   localparam int unsigned DIV = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       k0 = 1'b0;
   logic       k1 = 1'b0;
   logic [7:0] ks = 8'd0;
   logic       sdo, sstb, busy;
   logic       l1, l2, l3, l4, l5, l6, l7, l8;
   logic [7:0] num;
   logic [7:0] leds;

   assign leds = {l8, l7, l6, l5, l4, l3, l2, l1};

   seq_tx #(.DIV(DIV)) dut (
      .CLK (clk),
      .RST (rst_n),
      .K0  (k0),
      .K1  (k1),
      .Ks  (ks),
      .SDO (sdo),
      .SSTB(sstb),
      .BUSY(busy),
      .L1  (l1),
      .L2  (l2),
      .L3  (l3),
      .L4  (l4),
      .L5  (l5),
      .L6  (l6),
      .L7  (l7),
      .L8  (l8),
      .NUM (num)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   bit exp_q[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] num_of(input int c);
      case (c)
         0:       return 8'b1111_1100;
         1:       return 8'b0110_0000;
         2:       return 8'b1101_1010;
         3:       return 8'b1111_0010;
         default: return 8'b0000_0000;
      endcase
   endfunction

   // Pattern-window model: a match ends at bit i when bits i-2..i are 1,0,1; in
   // non-overlapping mode the window must start after the previous match ended.
   task automatic model(input logic [7:0] w, input bit ov, output logic [7:0] fl, output int c);
      int last_end;
      last_end = -1;
      fl = 8'd0;
      c  = 0;
      for (int i = 2; i < 8; i++) begin
         if (w[i-2] && !w[i-1] && w[i] && (ov || (i - 2 > last_end))) begin
            fl[i]    = 1'b1;
            c++;
            last_end = i;
         end
      end
   endtask

   // ---------------------------------------------------------------- monitor
   bit cur_bit   = 1'b0;
   bit busy_prev = 1'b0;
   int busy_len  = 0;
   int last_busy_len = 0;
   int gap = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         busy_prev = 1'b0;
         busy_len  = 0;
         gap       = 0;
      end else begin
         if (sstb) begin
            check("stb_busy", 32'(busy), 1);
            if (!busy_prev) begin
               check("clr_leds", 32'(leds), 0);
               check("clr_num", 32'(num), 32'h00FC);
            end else begin
               check("stb_gap", 32'(gap), DIV - 1);
            end
            check("stb_queued", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
               cur_bit = exp_q.pop_front();
               check("sdo_bit", 32'(sdo), 32'(cur_bit));
            end
            gap = 0;
         end else begin
            gap++;
            if (busy) check("sdo_hold", 32'(sdo), 32'(cur_bit));
            else      check("sdo_idle", 32'(sdo), 0);
         end
         if (busy) begin
            busy_len++;
         end else if (busy_prev) begin
            last_busy_len = busy_len;
            busy_len      = 0;
         end
         busy_prev = busy;
      end
   end

   // ---------------------------------------------------------------- stimulus
   logic [7:0] exp_fl;
   int         exp_c;

   // Presses K0 (left high) and checks raw-edge to first-strobe latency.
   task automatic launch(input logic [7:0] w, input bit ov);
      int k;
      ks = w;
      k1 = ov;
      model(w, ov, exp_fl, exp_c);
      for (int i = 0; i < 8; i++) exp_q.push_back(w[i]);
      @(posedge clk);
      #1 k0 = 1'b1;
      k = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         k++;
         if (sstb) break;
      end
      check("start_lat", 32'(k), 5);
   endtask

   task automatic finish_frame();
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (!busy) break;
      end
      check("busy_fall", 32'(busy), 0);
      @(negedge clk);
      check("busy_len", 32'(last_busy_len), 8 * DIV);
      check("queue_empty", 32'(exp_q.size()), 0);
      check("leds", 32'(leds), 32'(exp_fl));
      check("num", 32'(num), 32'(num_of(exp_c)));
   endtask

   task automatic expect_quiet(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         check("quiet_busy", 32'(busy), 0);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_sdo"}, 32'(sdo), 0);
      check({tag, "_sstb"}, 32'(sstb), 0);
      check({tag, "_busy"}, 32'(busy), 0);
      check({tag, "_leds"}, 32'(leds), 0);
      check({tag, "_num"}, 32'(num), 32'h00FC);
   endtask

   initial begin
      // Reset with arbitrary data/mode inputs.
      rst_n = 1'b0;
      ks    = 8'($urandom);
      k1    = 1'($urandom);
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("rst");
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (3) @(posedge clk);

      // Serialisation, with K0 held for the whole frame and beyond.
      launch(8'b1010_0101, 1'b1);
      finish_frame();
      check("t1_leds", 32'(leds), 32'b1000_0100);
      check("t1_num", 32'(num), 32'b1101_1010);
      expect_quiet(12);
      k0 = 1'b0;
      repeat (4) @(posedge clk);

      // Overlap vs non-overlap.
      launch(8'b0001_0101, 1'b1);
      k0 = 1'b0;
      finish_frame();
      check("ov_leds", 32'(leds), 32'b0001_0100);
      launch(8'b0001_0101, 1'b0);
      k0 = 1'b0;
      finish_frame();
      check("nov_leds", 32'(leds), 32'b0000_0100);
      check("nov_num", 32'(num), 32'b0110_0000);

      // Maximum count.
      launch(8'b0101_0101, 1'b1);
      k0 = 1'b0;
      finish_frame();
      check("max_leds", 32'(leds), 32'b0101_0100);
      check("max_num", 32'(num), 32'b1111_0010);

      // Mid-frame re-press and input changes are ignored.
      launch(8'h2D, 1'b1);
      repeat (6) @(negedge clk);
      k0 = 1'b0;
      repeat (3) @(negedge clk);
      k0 = 1'b1;
      ks = 8'hD2;
      k1 = 1'b0;
      repeat (3) @(negedge clk);
      k0 = 1'b0;
      finish_frame();
      check("ign_leds", 32'(leds), 32'b0010_0100);
      expect_quiet(10);
      launch(8'h15, 1'b0);
      k0 = 1'b0;
      finish_frame();

      // Reset mid-frame at bit 4, then a fresh complete frame.
      launch(8'hA5, 1'b0);
      k0 = 1'b0;
      begin
         int seen;
         seen = 0;
         for (int i = 0; i < 100 && seen < 4; i++) begin
            @(negedge clk);
            if (sstb) seen++;
         end
         check("bit4_reached", 32'(seen), 4);
      end
      rst_n = 1'b0;
      @(negedge clk);
      check_reset_outputs("midrst");
      exp_q.delete();
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (3) @(posedge clk);
      launch(8'h69, 1'b1);
      k0 = 1'b0;
      finish_frame();
      check("fresh_leds", 32'(leds), 32'b0010_0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/seq_tx.md
# seq_tx

Serial pattern transmitter for the lab board: on a start button press it latches the 8-bit switch word and shifts it out LSB-first, one bit per programmable bit period, with a per-bit strobe. It is the transmit side of the "101" sequence-detector experiment. While sending, it runs the same 101 detector (overlapping or non-overlapping mode) over the bits it emits. LEDs and the seven-segment digit show the pattern-end positions and count the receiving board must reproduce.

## Interface
Parameters:
- DIV, default 25000000: CLK cycles per transmitted bit; legal range 2..2^32-1.

Ports:
- CLK  in  1  system clock; all state changes on rising edge.
- RST  in  1  synchronous, active-low reset.
- K0  in  1  start button, raw level; 2-flop synchronised, rising edge starts a frame.
- K1  in  1  mode: 1 = overlapping count (after match go to S1), 0 = non-overlapping (after match go to S0); sampled at start.
- Ks  in  8  data word; latched at start; Ks[0] sent first.
- SDO  out  1  serial data, held for the full bit period.
- SSTB  out  1  one-CLK strobe in the first cycle of each bit period.
- BUSY  out  1  high from the first bit period through the end of the eighth.
- L1..L8  out  1 each  L(i+1) = 1 when bit i completed a "101" pattern.
- NUM  out  8  seven-segment {a,b,c,d,e,f,g,dp}, active-high, dp always 0; shows the running match count.

## Operation
- Frame FSM: IDLE, SEND, DONE.
  - IDLE -> SEND on a synchronised K0 rising edge.
  - SEND -> DONE after bit 7's period ends.
  - DONE -> IDLE in the following cycle.
- Start edge (cycle n) latches Ks into shift register, latches K1, clears flags, count, detector state (S0), bit index 0 and divider.
- Detector (one-hot S0=001, S1=010, S2=100) advances once per bit, on the SSTB cycle, using the bit being presented:
  - S0: 1 -> S1, else S0.
  - S1: 0 -> S2, else S1.
  - S2: 1 -> match (set flag[idx], count+1, next S1 if overlap else S0); 0 -> S0.
- Count width 3; maximum reachable is 3, so no saturation is needed.
- NUM encoding {a..g} by count:
  - 0 = 1111110
  - 1 = 0110000
  - 2 = 1101101
  - 3 = 1111001
  - any other value = 0000000
  - NUM = {seg, 1'b0}.
- Flags and count hold after DONE until the next start or reset.
- Start edges while BUSY=1 are ignored; the button must be released and pressed again.
- Ks and K1 changes after the start edge have no effect on the current frame.

## Timing
- Reset values, one cycle after RST=0 is sampled:
  - SDO=0, SSTB=0, BUSY=0, L1..L8=0, count=0, NUM=8'b11111100.
  - FSM=IDLE, synchroniser flops=0.
- Reset mid-frame aborts immediately with the same values; no partial bits continue.
- K0 raw rising edge to start edge: 2-cycle synchroniser plus 1 edge register, so the start edge is seen in cycle n = raw+3.
- Cycle n+1: BUSY=1, SSTB=1, SDO=Ks[0]. Flag and count updates for bit 0 are visible in cycle n+2.
- Bit i begins at cycle n+1+i·DIV; SSTB is high only in that cycle; SDO is stable for DIV cycles.
- Flag and count updates for bit i are visible one cycle after that bit's SSTB.
- BUSY falls and SDO returns to 0 at cycle n+1+8·DIV.
- A new start edge is accepted from cycle n+2+8·DIV.
- K0 held high continuously produces exactly one frame.

## Test plan
(DIV=4 for all scenarios.)
- Reset: RST=0 for 2 cycles with arbitrary inputs -> SDO=0, SSTB=0, BUSY=0, LEDs 0, NUM=8'hFC.
- Serialisation: Ks=8'b1010_0101, K1=1, pulse K0.
  - SDO sequence is 1,0,1,0,0,1,0,1, each bit 4 cycles.
  - SSTB gives 8 single-cycle pulses, 4 apart.
  - BUSY is high for 32 cycles.
  - L3=1, L8=1, count=2, NUM=8'b11011010.
- Overlap vs non-overlap: Ks=8'b0001_0101.
  - K1=1 -> L3, L5 set; count 2.
  - K1=0 -> only L3 set; count 1; NUM=8'b01100000.
- Maximum count: Ks=8'b0101_0101, K1=1 -> L3, L5, L7 set; count 3; NUM=8'b11110010.
- Ignored inputs: press K0 again and toggle Ks mid-frame -> transmitted bits equal the originally latched word; no second frame starts; a press after BUSY falls starts a new frame and clears the LEDs.
- Reset mid-frame: assert RST at bit 4 -> all outputs at reset values next cycle; a subsequent K0 press sends a complete fresh frame.
